fp_exception_pipe: RTL and testbench
====================================

// Module: fp_exception_pipe
// PURPOSE
//  Pipelined special-case classifier for the FPU add/sub/mul datapath. Runs in parallel with the arithmetic core.
//  Per operand pair it emits an exception code and a fully sign-resolved special result (NaN, Inf, zero or copied operand).
//  Generalised in exponent/mantissa width, with an ADD/SUB/MUL mode, a valid/ready handshake with backpressure,
//  a tag passthrough, sticky status and a saturating event counter.
// PARAMETERS
//  EXP_BITS   8    exponent field width
//  MANT_BITS  23   fraction field width; WIDTH = 1+EXP_BITS+MANT_BITS (localparam)
//  TAG_W      4    width of sideband tag carried with each operation
//  CNT_W      16   width of saturating special-event counter
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        synchronous reset, active-high
//  in_valid    in   1        operand pair valid
//  in_ready    out  1        block can accept; transfer when in_valid&&in_ready
//  in_a        in   WIDTH    operand A
//  in_b        in   WIDTH    operand B
//  in_op       in   2        00 ADD, 01 SUB, 10 MUL, 11 reserved
//  in_tag      in   TAG_W    sideband, returned unchanged on out_tag
//  out_valid   out  1        result valid
//  out_ready   in   1        consumer accepts; transfer when out_valid&&out_ready
//  out_flag    out  3        exception code (see STRUCTURE)
//  out_result  out  WIDTH    special result; all zeros when out_flag==NONE
//  out_tag     out  TAG_W    tag of this result
//  clr_sts     in   1        one-cycle pulse clearing sts_invalid and sts_cnt
//  sts_invalid out  1        sticky: invalid operation produced since last clear
//  sts_cnt     out  CNT_W    saturating count of delivered results with out_flag!=NONE
// BEHAVIOUR
//  Reset: all valids, out_flag, out_result, out_tag, sts_invalid, sts_cnt = 0. A mid-flight op is discarded.
//  Pipeline: S1 registers operands + per-operand class; S2 registers flag/result. Latency 2 cycles when not stalled.
//  Stall: S2 loads when !s2_valid||out_ready. S1 loads when !s1_valid||S2 loads. in_ready = S1 load condition.
//   Outputs hold stable while out_valid&&!out_ready. No loss, duplication or reordering. Throughput 1/cycle.
//  Decision priority, ADD/SUB (eb = b_sign^op[0]):
//   any NaN -> NAN, qNaN {0,1..1,1,0..0}; inf&inf: a_sign==eb -> COPY_A (a), else NAN + invalid;
//   a inf -> COPY_A (a); b inf -> COPY_B ({eb,|b|}); both zero -> ZERO ({a_sign&eb,0});
//   a zero -> COPY_B ({eb,|b|}); b zero -> COPY_A (a); |a|==|b| && a_sign!=eb -> CANCEL (+0); else NONE.
//  MUL (s=a_sign^b_sign): any NaN -> NAN; inf*zero -> NAN + invalid; any inf -> INF ({s,1..1,0});
//   any zero -> ZERO ({s,0}); else NONE.
//  op 11 -> NAN, qNaN, invalid.
//  Status: updated only on output transfer. Invalid event sets sts_invalid; flag!=NONE increments sts_cnt.
//   sts_cnt holds at all-ones. clr_sts coincident with an event: the clear applies first, then the event
//   records (sts_invalid=event, sts_cnt=0 or 1).
// CONFIGURATION
//  FPU_EXC_DENORM_EN defined: subnormals (exp==0, frac!=0) are finite nonzero values and classify as NONE.
//  Undefined (default): subnormals are flushed and classified as zero of their sign.
//   The copied operand is also flushed, e.g. COPY_A of subnormal a returns {a_sign,0}.
// STRUCTURE
//  Package fpu_exc_pkg: flag localparams NONE=0, NAN=1, COPY_A=2, COPY_B=3, INF=4, ZERO=5, CANCEL=6, 7 reserved;
//   op codes OP_ADD/OP_SUB/OP_MUL; class encoding (ZERO, SUB, NORM, INF, NAN).
//  Sub-module fp_classify: combinational, per operand, {EXP_BITS,MANT_BITS} -> class. Two instances in S1.
// TESTING (single precision)
//  ADD 7F800000+FF800000 -> after 2 cycles NAN, result 7FC00000, sts_invalid=1, sts_cnt=1
//  SUB 3F800000-3F800000 -> CANCEL, 00000000; SUB 00000000-40000000 -> COPY_B, C0000000
//  MUL FF800000*40000000 -> INF, FF800000; MUL 80000000*3F800000 -> ZERO, 80000000; MUL 7F800000*0 -> NAN
//  out_ready=0 with 3 back-to-back inputs (tags 1,2,3) -> 2 accepted, in_ready=0, out held;
//   release -> tags 1,2,3 in order, once each
//  ADD 00000001+3F800000 -> COPY_B 3F800000 (default); NONE, 0 with FPU_EXC_DENORM_EN
//  clr_sts with coincident invalid transfer -> sts_invalid=1, sts_cnt=1; rst with S1/S2 full -> next cycle all zero

Source files
------------

// File: rtl/fpu_exc_pkg.sv
// rtl/fpu_exc_pkg.sv - shared flag, op and operand-class encodings for the FPU exception pipe
package fpu_exc_pkg;

  localparam logic [2:0] FLAG_NONE   = 3'd0;
  localparam logic [2:0] FLAG_NAN    = 3'd1;
  localparam logic [2:0] FLAG_COPY_A = 3'd2;
  localparam logic [2:0] FLAG_COPY_B = 3'd3;
  localparam logic [2:0] FLAG_INF    = 3'd4;
  localparam logic [2:0] FLAG_ZERO   = 3'd5;
  localparam logic [2:0] FLAG_CANCEL = 3'd6;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational operand classifier; FPU_EXC_DENORM_EN keeps subnormals as finite values
module fp_classify
  import fpu_exc_pkg::*;
#(
  parameter int EXP_BITS  = 8,
  parameter int MANT_BITS = 23
) (
  input  logic [EXP_BITS-1:0]  exp_f,
  input  logic [MANT_BITS-1:0] frac_f,
  output logic [2:0]           cls
);

  always_comb begin
    cls = CLS_NORM;
    if (exp_f == '1) begin
      cls = (frac_f == '0) ? CLS_INF : CLS_NAN;
    end else if (exp_f == '0) begin
      if (frac_f == '0) begin
        cls = CLS_ZERO;
      end else begin
`ifdef FPU_EXC_DENORM_EN
        cls = CLS_SUB;
`else
        cls = CLS_ZERO;
`endif
      end
    end
  end

endmodule

// File: rtl/fp_exception_pipe.sv
// rtl/fp_exception_pipe.sv - two-stage special-case classifier for add/sub/mul; FPU_EXC_DENORM_EN selects subnormal handling
module fp_exception_pipe
  import fpu_exc_pkg::*;
#(
  parameter int  EXP_BITS  = 8,
  parameter int  MANT_BITS = 23,
  parameter int  TAG_W     = 4,
  parameter int  CNT_W     = 16,
  localparam int WIDTH     = 1 + EXP_BITS + MANT_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_flag,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  input  logic             clr_sts,
  output logic             sts_invalid,
  output logic [CNT_W-1:0] sts_cnt
);

  localparam logic [WIDTH-1:0] QNAN =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

  logic             s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [1:0]       s1_op;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [2:0]       s1_cls_a, s1_cls_b, cls_a_in, cls_b_in;
  logic [2:0]       s2_flag;
  logic [WIDTH-1:0] s2_result;
  logic             s2_invalid;
  logic             s1_load, s2_load, out_fire;

  fp_classify #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS)) u_cls_a (
    .exp_f (in_a[WIDTH-2:MANT_BITS]),
    .frac_f(in_a[MANT_BITS-1:0]),
    .cls   (cls_a_in)
  );

  fp_classify #(.EXP_BITS(EXP_BITS), .MANT_BITS(MANT_BITS)) u_cls_b (
    .exp_f (in_b[WIDTH-2:MANT_BITS]),
    .frac_f(in_b[MANT_BITS-1:0]),
    .cls   (cls_b_in)
  );

  assign s2_load  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign out_fire = s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_cls_a <= CLS_ZERO;
      s1_cls_b <= CLS_ZERO;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
      s1_tag   <= in_tag;
      s1_cls_a <= cls_a_in;
      s1_cls_b <= cls_b_in;
    end
  end

  // Flushed subnormals classify as zero, so their magnitude must read as zero when copied.
  logic             a_sign, eb, ms;
  logic [WIDTH-2:0] a_mag, b_mag;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [2:0]       dec_flag;
  logic [WIDTH-1:0] dec_result;
  logic             dec_invalid;

  assign a_sign = s1_a[WIDTH-1];
  assign eb     = s1_b[WIDTH-1] ^ s1_op[0];
  assign ms     = s1_a[WIDTH-1] ^ s1_b[WIDTH-1];
  assign a_nan  = (s1_cls_a == CLS_NAN);
  assign b_nan  = (s1_cls_b == CLS_NAN);
  assign a_inf  = (s1_cls_a == CLS_INF);
  assign b_inf  = (s1_cls_b == CLS_INF);
  assign a_zero = (s1_cls_a == CLS_ZERO);
  assign b_zero = (s1_cls_b == CLS_ZERO);
  assign a_mag  = a_zero ? '0 : s1_a[WIDTH-2:0];
  assign b_mag  = b_zero ? '0 : s1_b[WIDTH-2:0];

  always_comb begin
    dec_flag    = FLAG_NONE;
    dec_result  = '0;
    dec_invalid = 1'b0;
    if (s1_op == 2'b11) begin
      dec_flag    = FLAG_NAN;
      dec_result  = QNAN;
      dec_invalid = 1'b1;
    end else if (s1_op == OP_MUL) begin
      if (a_nan || b_nan) begin
        dec_flag   = FLAG_NAN;
        dec_result = QNAN;
      end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        dec_flag    = FLAG_NAN;
        dec_result  = QNAN;
        dec_invalid = 1'b1;
      end else if (a_inf || b_inf) begin
        dec_flag   = FLAG_INF;
        dec_result = {ms, {EXP_BITS{1'b1}}, {MANT_BITS{1'b0}}};
      end else if (a_zero || b_zero) begin
        dec_flag   = FLAG_ZERO;
        dec_result = {ms, {(WIDTH-1){1'b0}}};
      end
    end else begin
      if (a_nan || b_nan) begin
        dec_flag   = FLAG_NAN;
        dec_result = QNAN;
      end else if (a_inf && b_inf) begin
        if (a_sign == eb) begin
          dec_flag   = FLAG_COPY_A;
          dec_result = {a_sign, a_mag};
        end else begin
          dec_flag    = FLAG_NAN;
          dec_result  = QNAN;
          dec_invalid = 1'b1;
        end
      end else if (a_inf) begin
        dec_flag   = FLAG_COPY_A;
        dec_result = {a_sign, a_mag};
      end else if (b_inf) begin
        dec_flag   = FLAG_COPY_B;
        dec_result = {eb, b_mag};
      end else if (a_zero && b_zero) begin
        dec_flag   = FLAG_ZERO;
        dec_result = {a_sign & eb, {(WIDTH-1){1'b0}}};
      end else if (a_zero) begin
        dec_flag   = FLAG_COPY_B;
        dec_result = {eb, b_mag};
      end else if (b_zero) begin
        dec_flag   = FLAG_COPY_A;
        dec_result = {a_sign, a_mag};
      end else if ((a_mag == b_mag) && (a_sign != eb)) begin
        dec_flag   = FLAG_CANCEL;
        dec_result = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_flag    <= FLAG_NONE;
      s2_result  <= '0;
      s2_tag     <= '0;
      s2_invalid <= 1'b0;
    end else if (s2_load) begin
      s2_valid   <= s1_valid;
      s2_flag    <= s1_valid ? dec_flag : FLAG_NONE;
      s2_result  <= s1_valid ? dec_result : '0;
      s2_tag     <= s1_valid ? s1_tag : '0;
      s2_invalid <= s1_valid & dec_invalid;
    end
  end

  // A clear coincident with a delivery wipes history first, then records the delivered event.
  always_ff @(posedge clk) begin
    if (rst) begin
      sts_invalid <= 1'b0;
      sts_cnt     <= '0;
    end else if (out_fire) begin
      if (clr_sts) begin
        sts_invalid <= s2_invalid;
        sts_cnt     <= (s2_flag != FLAG_NONE) ? CNT_W'(1) : '0;
      end else begin
        if (s2_invalid) sts_invalid <= 1'b1;
        if ((s2_flag != FLAG_NONE) && (sts_cnt != '1)) sts_cnt <= sts_cnt + CNT_W'(1);
      end
    end else if (clr_sts) begin
      sts_invalid <= 1'b0;
      sts_cnt     <= '0;
    end
  end

  assign out_valid  = s2_valid;
  assign out_flag   = s2_flag;
  assign out_result = s2_result;
  assign out_tag    = s2_tag;

endmodule

// File: tb/tb_fp_exception_pipe.sv
// tb/tb_fp_exception_pipe.sv - randomized scoreboard bench for fp_exception_pipe (single precision)
module tb_fp_exception_pipe;

  localparam logic [31:0] QNAN = 32'h7FC00000;
`ifdef FPU_EXC_DENORM_EN
  localparam bit FLUSH = 1'b0;
`else
  localparam bit FLUSH = 1'b1;
`endif

  typedef struct packed {
    logic [3:0]  tag;
    logic [2:0]  flag;
    logic [31:0] res;
    logic        inv;
  } item_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, clr_sts, sts_invalid;
  logic [31:0] in_a, in_b, out_result;
  logic [1:0]  in_op;
  logic [3:0]  in_tag, out_tag, sts_cnt;
  logic [2:0]  out_flag;

  int    checks = 0;
  int    errors = 0;
  item_t q[$];
  logic  m_inv;
  logic [3:0] m_cnt;
  logic  prev_held;
  logic  seen_ov;

  fp_exception_pipe #(.EXP_BITS(8), .MANT_BITS(23), .TAG_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_flag(out_flag),
    .out_result(out_result), .out_tag(out_tag), .clr_sts(clr_sts),
    .sts_invalid(sts_invalid), .sts_cnt(sts_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Value-level reference: field predicates on IEEE single precision, rule list in priority order.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic an, bn, ai, bi, az, bz, eb, s, iv;
    logic [30:0] am, bm;
    logic [2:0]  f;
    logic [31:0] r;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00) && (FLUSH || a[22:0] == 0);
    bz = (b[30:23] == 8'h00) && (FLUSH || b[22:0] == 0);
    am = az ? 31'd0 : a[30:0];
    bm = bz ? 31'd0 : b[30:0];
    eb = b[31] ^ op[0];
    s  = a[31] ^ b[31];
    f = 3'd0; r = 32'd0; iv = 1'b0;
    if (op == 2'd3) begin f = 3'd1; r = QNAN; iv = 1'b1; end
    else if (op == 2'd2) begin
      if (an || bn)                    begin f = 3'd1; r = QNAN; end
      else if ((ai && bz) || (az && bi)) begin f = 3'd1; r = QNAN; iv = 1'b1; end
      else if (ai || bi)               begin f = 3'd4; r = {s, 8'hFF, 23'd0}; end
      else if (az || bz)               begin f = 3'd5; r = {s, 31'd0}; end
    end else begin
      if (an || bn)                    begin f = 3'd1; r = QNAN; end
      else if (ai && bi) begin
        if (a[31] == eb) begin f = 3'd2; r = a; end
        else begin f = 3'd1; r = QNAN; iv = 1'b1; end
      end
      else if (ai)                     begin f = 3'd2; r = a; end
      else if (bi)                     begin f = 3'd3; r = {eb, bm}; end
      else if (az && bz)               begin f = 3'd5; r = {a[31] & eb, 31'd0}; end
      else if (az)                     begin f = 3'd3; r = {eb, bm}; end
      else if (bz)                     begin f = 3'd2; r = {a[31], am}; end
      else if (am == bm && a[31] != eb) begin f = 3'd6; r = 32'd0; end
    end
    return {f, r, iv};
  endfunction

  // One clock of stimulus; lit selects a literal expected result instead of the model.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [3:0] tag, input logic ordy,
                      input logic clr, input logic lit, input logic [2:0] lf,
                      input logic [31:0] lr, input logic li);
    item_t it;
    in_valid = v; in_a = a; in_b = b; in_op = op; in_tag = tag;
    out_ready = ordy; clr_sts = clr;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || ordy});
    if (prev_held) chk("held_valid", {31'd0, out_valid}, 32'd1);
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out", 32'd1, 32'd0);
      else chk("out_tag", {28'd0, out_tag}, {28'd0, q[0].tag});
    end
    if (out_valid && out_ready && q.size() != 0) begin
      it = q.pop_front();
      chk("out_flag", {29'd0, out_flag}, {29'd0, it.flag});
      chk("out_result", out_result, it.res);
      if (clr) begin
        m_inv = it.inv;
        m_cnt = (it.flag != 0) ? 4'd1 : 4'd0;
      end else begin
        m_inv = m_inv | it.inv;
        if (it.flag != 0 && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
      end
    end else if (clr) begin
      m_inv = 1'b0;
      m_cnt = 4'd0;
    end
    if (in_valid && in_ready) begin
      it.tag = tag;
      if (lit) {it.flag, it.res, it.inv} = {lf, lr, li};
      else     {it.flag, it.res, it.inv} = model(a, b, op);
      q.push_back(it);
    end
    prev_held = out_valid && !out_ready;
    seen_ov   = out_valid;
    @(posedge clk); #1;
    chk("sts_invalid", {31'd0, sts_invalid}, {31'd0, m_inv});
    chk("sts_cnt", {28'd0, sts_cnt}, {28'd0, m_cnt});
  endtask

  task automatic idle(input logic clr);
    step(1'b0, 32'd0, 32'd0, 2'd0, 4'd0, 1'b1, clr, 1'b0, 3'd0, 32'd0, 1'b0);
  endtask

  task automatic dir(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                     input logic [3:0] tag, input logic [2:0] lf, input logic [31:0] lr,
                     input logic li);
    step(1'b1, a, b, op, tag, 1'b1, 1'b0, 1'b1, lf, lr, li);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b0);
    chk("drain_empty", q.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 12)
      0: return 32'h00000000;
      1: return 32'h80000000;
      2: return 32'h7F800000;
      3: return 32'hFF800000;
      4: return 32'h7FC00000;
      5: return 32'hFF800001;
      6: return 32'h3F800000;
      7: return 32'hBF800000;
      8: return 32'h40000000;
      9: return 32'h00000001;
      10: return 32'h807FFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [31:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b0; clr_sts = 1'b0;
    m_inv = 1'b0; m_cnt = '0; prev_held = 1'b0; seen_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_flag", {29'd0, out_flag}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_sts", {27'd0, sts_invalid, sts_cnt}, 32'd0);
    rst = 1'b0;

    dir(32'h7F800000, 32'hFF800000, 2'd0, 4'd1, 3'd1, 32'h7FC00000, 1'b1);
    idle(1'b0);
    idle(1'b0);
    chk("inf_minus_inf_sts_invalid", {31'd0, sts_invalid}, 32'd1);
    chk("inf_minus_inf_sts_cnt", {28'd0, sts_cnt}, 32'd1);

    dir(32'h3F800000, 32'h3F800000, 2'd1, 4'd2, 3'd6, 32'h00000000, 1'b0);
    dir(32'h00000000, 32'h40000000, 2'd1, 4'd3, 3'd3, 32'hC0000000, 1'b0);
    dir(32'hFF800000, 32'h40000000, 2'd2, 4'd4, 3'd4, 32'hFF800000, 1'b0);
    dir(32'h80000000, 32'h3F800000, 2'd2, 4'd5, 3'd5, 32'h80000000, 1'b0);
    dir(32'h7F800000, 32'h00000000, 2'd2, 4'd6, 3'd1, 32'h7FC00000, 1'b1);
`ifdef FPU_EXC_DENORM_EN
    dir(32'h00000001, 32'h3F800000, 2'd0, 4'd7, 3'd0, 32'h00000000, 1'b0);
`else
    dir(32'h00000001, 32'h3F800000, 2'd0, 4'd7, 3'd3, 32'h3F800000, 1'b0);
`endif
    dir(32'h40000000, 32'h3F800000, 2'd3, 4'd8, 3'd1, 32'h7FC00000, 1'b1);
    drain();

    // Latency: accepted op appears on the second following cycle.
    idle(1'b1);
    dir(32'h00000000, 32'h3F800000, 2'd2, 4'd9, 3'd5, 32'h00000000, 1'b0);
    n = 0;
    seen_ov = 1'b0;
    while (!seen_ov && n < 10) begin idle(1'b0); n++; end
    chk("latency", n, 32'd2);
    dir(32'h00000000, 32'h3F800000, 2'd2, 4'd10, 3'd5, 32'h00000000, 1'b0);
    dir(32'h00000000, 32'h3F800000, 2'd2, 4'd11, 3'd5, 32'h00000000, 1'b0);
    dir(32'h7F800000, 32'hFF800000, 2'd0, 4'd12, 3'd1, 32'h7FC00000, 1'b1);
    idle(1'b0);
    idle(1'b1);
    chk("clr_coincident_invalid", {31'd0, sts_invalid}, 32'd1);
    chk("clr_coincident_cnt", {28'd0, sts_cnt}, 32'd1);
    drain();

    // Backpressure: third input must wait, release delivers 1,2,3 in order.
    step(1'b1, 32'h3F800000, 32'h40000000, 2'd0, 4'd1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step(1'b1, 32'h7F800000, 32'h40000000, 2'd1, 4'd2, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step(1'b1, 32'h00000000, 32'h40000000, 2'd0, 4'd3, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    chk("bp_queue_depth", q.size(), 32'd2);
    step(1'b1, 32'h00000000, 32'h40000000, 2'd0, 4'd3, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    drain();

    for (int i = 0; i < 800; i++) begin
      ra = pick();
      rb = ($urandom % 5 == 0) ? (ra ^ ({31'd0, 1'($urandom)} << 31)) : pick();
      step(1'($urandom % 3 != 0), ra, rb, 2'($urandom), 4'($urandom),
           1'($urandom % 4 != 0), 1'($urandom % 60 == 0), 1'b0, 3'd0, 32'd0, 1'b0);
    end
    drain();

    // Reset with both stages occupied discards everything.
    step(1'b1, 32'h7F800001, 32'h3F800000, 2'd2, 4'hA, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    step(1'b1, 32'h7F800000, 32'hFF800000, 2'd0, 4'hB, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_flag", {29'd0, out_flag}, 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("midrst_sts", {27'd0, sts_invalid, sts_cnt}, 32'd0);
    rst = 1'b0;
    q.delete();
    m_inv = 1'b0; m_cnt = '0; prev_held = 1'b0;
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
